// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO with sticky overflow
// and frame-error flags for the register port.
module uart_rx_fifo #(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rx_pop,
    input  logic                          clear_errors,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overflow,
    output logic                          frame_error
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [2:0]         bit_idx, bit_next;
    logic               sync_p0, sync_p1;
    logic               rx_s;
    logic               shift_en, stop_ok, stop_bad;
    logic [7:0]         shift_reg;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic               pop_eff, full, push, ovf_set;

    // Synchronizer stage: line is asynchronous to clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= uart_rx;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_s = sync_p1;

    // Receiver FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        shift_en   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bit_next   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        stop_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift register and FIFO storage carry no reset
    always_ff @(posedge clock) begin
        if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
        if (push)     mem[wptr] <= shift_reg;
    end

    assign pop_eff = rx_pop && (rx_count != '0);
    assign full    = (rx_count == CNT_FULL);
    assign push    = stop_ok && (!full || pop_eff);
    assign ovf_set = stop_ok && full && !pop_eff;

    // FIFO pointers, occupancy and sticky flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            rx_count    <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (push)    wptr <= wptr + 1'b1;
            if (pop_eff) rptr <= rptr + 1'b1;
            case ({push, pop_eff})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            overflow    <= ovf_set  | (overflow    & ~clear_errors);
            frame_error <= stop_bad | (frame_error & ~clear_errors);
        end
    end

    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven bit-by-bit and
// expected bytes queued at send time, then compared as they are popped.
module tb_uart_rx_fifo;

    localparam int CPB   = 25000000 / 115200;
    localparam int DEPTH = 8;
    localparam int STOP_EDGE = CPB / 2 + 3 + 9 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_pop = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       overflow;
    logic       frame_error;

    int checks = 0;
    int fails  = 0;
    logic [7:0] sb [$];
    logic       v_before, v_after;
    logic [7:0] d_after, head_at_pop;

    uart_rx_fifo #(
        .CLOCK_FREQUENCY(25000000),
        .BAUD_RATE(115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .uart_rx(uart_rx),
        .rx_pop(rx_pop),
        .clear_errors(clear_errors),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_count(rx_count),
        .overflow(overflow),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] f, input int ncyc, input int pop_c);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock);
            #1;
            if (c == STOP_EDGE - 1) v_before = rx_valid;
            if (c == STOP_EDGE) begin
                v_after = rx_valid;
                d_after = rx_data;
            end
            if (c == pop_c) head_at_pop = rx_data;
            uart_rx = f[c / CPB];
            rx_pop  = (c == pop_c);
        end
        @(posedge clock);
        #1;
        rx_pop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int pop_c);
        send_bits({6'h3F, 1'b1, d, 1'b0}, 10 * CPB, pop_c);
    endtask

    task automatic do_pop(output logic [7:0] d);
        d = rx_data;
        rx_pop = 1'b1;
        @(posedge clock);
        #1;
        rx_pop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(100);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (frame_error !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        sb.push_back(8'hAB);
        send_byte(8'hAB, -1);
        checks++; if (v_before !== 1'b0) begin fails++; $display("FAIL lat_before got=%b exp=0", v_before); end
        checks++; if (v_after !== 1'b1) begin fails++; $display("FAIL lat_after got=%b exp=1", v_after); end
        checks++; if (d_after !== 8'hAB) begin fails++; $display("FAIL lat_data got=%h exp=ab", d_after); end
        checks++; if (rx_count !== 4'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", rx_count); end
        do_pop(d);
        checks++; if (d !== sb.pop_front()) begin fails++; $display("FAIL single_data got=%h exp=ab", d); end
        checks++; if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin
            fails++; $display("FAIL single_drain valid=%b count=%0d exp 0/0", rx_valid, rx_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d, e;
        logic exp_ovf = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (sb.size() < DEPTH) sb.push_back(8'(i));
            else exp_ovf = 1'b1;
            send_bits({6'h3F, 1'b1, 8'(i), 1'b0}, 10 * CPB, -1);
        end
        checks++; if (rx_count !== 4'(sb.size())) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", rx_count, sb.size()); end
        checks++; if (overflow !== exp_ovf) begin fails++; $display("FAIL b2b_ovf got=%b exp=%b", overflow, exp_ovf); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            do_pop(d);
            checks++; if (d !== e) begin fails++; $display("FAIL b2b_data got=%h exp=%h", d, e); end
        end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clear_errors = 1'b1;
        idle(1);
        clear_errors = 1'b0;
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_glitch_and_frame_error;
        logic [7:0] d;
        uart_rx = 1'b0;
        idle(50);
        uart_rx = 1'b1;
        idle(3 * CPB);
        checks++; if (rx_count !== 4'd0 || overflow !== 1'b0 || frame_error !== 1'b0) begin
            fails++; $display("FAIL glitch count=%0d ovf=%b ferr=%b exp 0/0/0", rx_count, overflow, frame_error);
        end
        send_bits({3'b111, 1'b1, 3'b000, 8'h3C, 1'b0}, 13 * CPB, -1);
        checks++; if (frame_error !== 1'b1) begin fails++; $display("FAIL ferr_set got=%b exp=1", frame_error); end
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL ferr_nopush got=%0d exp=0", rx_count); end
        sb.push_back(8'h5A);
        send_byte(8'h5A, -1);
        do_pop(d);
        checks++; if (d !== sb.pop_front()) begin fails++; $display("FAIL after_ferr got=%h exp=5a", d); end
        clear_errors = 1'b1;
        idle(1);
        clear_errors = 1'b0;
        checks++; if (frame_error !== 1'b0) begin fails++; $display("FAIL ferr_clear got=%b exp=0", frame_error); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] d, e;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'h10 + 8'(i));
            send_byte(8'h10 + 8'(i), -1);
        end
        checks++; if (rx_count !== 4'd8) begin fails++; $display("FAIL full_count got=%0d exp=8", rx_count); end
        send_byte(8'h77, STOP_EDGE - 1);
        e = sb.pop_front();
        sb.push_back(8'h77);
        checks++; if (head_at_pop !== e) begin fails++; $display("FAIL full_pop_head got=%h exp=%h", head_at_pop, e); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf got=%b exp=0", overflow); end
        checks++; if (rx_count !== 4'd8) begin fails++; $display("FAIL full_keep got=%0d exp=8", rx_count); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            do_pop(d);
            checks++; if (d !== e) begin fails++; $display("FAIL full_data got=%h exp=%h", d, e); end
        end
        rx_pop = 1'b1;
        idle(1);
        rx_pop = 1'b0;
        idle(1);
        checks++; if (rx_count !== 4'd0 || rx_valid !== 1'b0) begin
            fails++; $display("FAIL empty_pop count=%0d valid=%b exp 0/0", rx_count, rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        send_bits({6'h3F, 1'b1, 8'h00, 1'b0}, 5 * CPB + CPB / 2, -1);
        reset = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(50);
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL midrst_count got=%0d exp=0", rx_count); end
        sb.push_back(8'hC3);
        send_byte(8'hC3, -1);
        checks++; if (rx_count !== 4'd1) begin fails++; $display("FAIL midrst_after got=%0d exp=1", rx_count); end
        do_pop(d);
        checks++; if (d !== sb.pop_front()) begin fails++; $display("FAIL midrst_data got=%h exp=c3", d); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch_and_frame_error;
        test_full_push_pop;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
